// File: rtl/decoder_n_pipe.sv
// -----------------------------------------------------------------------------
// decoder_n_pipe
//
// Pipelined, parametrised binary-to-vector decoder with a valid/ready
// handshake on both sides. The decode is combinational on the input side.
// The result lands in a registered output stage that is backed by a
// one-entry skid buffer. Both handshake directions are therefore registered
// and the block still sustains one transaction per cycle.
//
// Decode modes (in_mode), with k = in_code:
//   2'b00 one-hot            bit i = (i == k)
//   2'b01 inverted one-hot   bit i = (i != k)
//   2'b10 thermometer-low    bit i = (i <= k)
//   2'b11 thermometer-high   bit i = (i >= k)
// Codes with k >= SIZE decode to all-zero and carry out_err = 1. They are
// still delivered downstream.
//
// Optional feature, selected by the macro DECODER_N_PIPE_ERR_COUNT_EN:
//   defined   -> err_count is a 16-bit saturating count of output transfers
//                that have out_err = 1. Only reset clears it.
//   undefined -> err_count is tied to 16'h0000 and no counter flops exist.
//
// Parameters:
//   SIZE   number of decoded outputs (2..256)
//   ENC_W  encoded input width, derived from SIZE
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   input transaction present
//   in_ready   out  block can accept an input this cycle
//   in_code    in   binary code [ENC_W-1:0]
//   in_mode    in   decode mode [1:0]
//   out_valid  out  decoded result present
//   out_ready  in   downstream accepts the result
//   out_vec    out  decoded vector [SIZE-1:0]
//   out_err    out  code of this result was out of range
//   err_count  out  out-of-range delivery count [15:0]
// -----------------------------------------------------------------------------
module decoder_n_pipe #(
    parameter int SIZE = 8,
    // Bits needed to hold SIZE-1. For SIZE >= 2 this equals ceil(log2(SIZE)).
    localparam int ENC_W = $clog2(SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ENC_W-1:0] in_code,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_vec,
    output logic             out_err,
    output logic [15:0]      err_count
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b10;

    // Returns {err, vec} for one code and mode.
    function automatic logic [SIZE:0] decode(input logic [ENC_W-1:0] code,
                                             input logic [1:0]       mode);
        logic [SIZE-1:0] vec;
        logic            err;
        int              k;
        k   = int'(code);
        vec = {SIZE{1'b0}};
        err = 1'b0;
        if (k >= SIZE) begin
            err = 1'b1;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                case (mode)
                    2'b00:   vec[i] = (i == k);
                    2'b01:   vec[i] = (i != k);
                    2'b10:   vec[i] = (i <= k);
                    2'b11:   vec[i] = (i >= k);
                    default: vec[i] = 1'b0;
                endcase
            end
        end
        return {err, vec};
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_out_valid;
    logic            w_in_ready;
    logic            w_acc;
    logic            w_drn;
    logic [SIZE-1:0] w_dec_vec;
    logic            w_dec_err;
    logic            w_load_dec;
    logic            w_load_skid;
    logic            w_fill_skid;
    logic [SIZE-1:0] r_out_vec;
    logic            r_out_err;
    logic [SIZE-1:0] r_skid_vec;
    logic            r_skid_err;

    // Handshake strobes and the combinational decode ahead of the registers.
    always_comb begin
        w_acc = in_valid && w_in_ready;
        w_drn = w_out_valid && out_ready;
        {w_dec_err, w_dec_vec} = decode(in_code, in_mode);
    end

    // Output stage state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic of the output stage.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) w_state_nxt = ST_FULL;
                else       w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_acc && w_drn)  w_state_nxt = ST_FULL;
                else if (w_acc)      w_state_nxt = ST_SKID;
                else if (w_drn)      w_state_nxt = ST_EMPTY;
                else                 w_state_nxt = ST_FULL;
            end
            ST_SKID: begin
                if (w_drn) w_state_nxt = ST_FULL;
                else       w_state_nxt = ST_SKID;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs depend only on the state register. in_ready has no
    // path from out_ready.
    always_comb begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b1;
        case (r_state)
            ST_EMPTY: begin
                w_out_valid = 1'b0;
                w_in_ready  = 1'b1;
            end
            ST_FULL: begin
                w_out_valid = 1'b1;
                w_in_ready  = 1'b1;
            end
            ST_SKID: begin
                w_out_valid = 1'b1;
                w_in_ready  = 1'b0;
            end
            default: begin
                w_out_valid = 1'b0;
                w_in_ready  = 1'b1;
            end
        endcase
    end

    // Data-path steering. New data goes straight to the output when it is
    // empty or draining. Otherwise it parks in the skid. A drain in the skid
    // state promotes the parked entry.
    always_comb begin
        w_load_dec  = w_acc && (!w_out_valid || w_drn);
        w_load_skid = (r_state == ST_SKID) && w_drn;
        w_fill_skid = w_acc && w_out_valid && !w_drn;
    end

    // Output register. It holds its value while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_vec <= {SIZE{1'b0}};
            r_out_err <= 1'b0;
        end else if (w_load_dec) begin
            r_out_vec <= w_dec_vec;
            r_out_err <= w_dec_err;
        end else if (w_load_skid) begin
            r_out_vec <= r_skid_vec;
            r_out_err <= r_skid_err;
        end
    end

    // Skid register. It stores an already-decoded entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skid_vec <= {SIZE{1'b0}};
            r_skid_err <= 1'b0;
        end else if (w_fill_skid) begin
            r_skid_vec <= w_dec_vec;
            r_skid_err <= w_dec_err;
        end
    end

`ifdef DECODER_N_PIPE_ERR_COUNT_EN
    logic [15:0] r_err_count;

    // Saturating count of delivered out-of-range transactions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_count <= 16'h0000;
        end else if (w_drn && r_out_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'h0001;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'h0000;
`endif

    assign out_valid = w_out_valid;
    assign in_ready  = w_in_ready;
    assign out_vec   = r_out_vec;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_decoder_n_pipe.sv
module tb_decoder_n_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // SIZE = 8 instance
    logic       v8, rdy8, ir8, ov8, oe8;
    logic [2:0] c8;
    logic [1:0] m8;
    logic [7:0] vec8;
    logic [15:0] ec8;
    // SIZE = 5 instance
    logic       v5, rdy5, ir5, ov5, oe5;
    logic [2:0] c5;
    logic [1:0] m5;
    logic [4:0] vec5;
    logic [15:0] ec5;
    // SIZE = 6 instance
    logic       v6, rdy6, ir6, ov6, oe6;
    logic [2:0] c6;
    logic [1:0] m6;
    logic [5:0] vec6;
    logic [15:0] ec6;

    decoder_n_pipe #(.SIZE(8)) u8 (
        .clock(clk), .reset(rst), .in_valid(v8), .in_ready(ir8), .in_code(c8),
        .in_mode(m8), .out_valid(ov8), .out_ready(rdy8), .out_vec(vec8),
        .out_err(oe8), .err_count(ec8));
    decoder_n_pipe #(.SIZE(5)) u5 (
        .clock(clk), .reset(rst), .in_valid(v5), .in_ready(ir5), .in_code(c5),
        .in_mode(m5), .out_valid(ov5), .out_ready(rdy5), .out_vec(vec5),
        .out_err(oe5), .err_count(ec5));
    decoder_n_pipe #(.SIZE(6)) u6 (
        .clock(clk), .reset(rst), .in_valid(v6), .in_ready(ir6), .in_code(c6),
        .in_mode(m6), .out_valid(ov6), .out_ready(rdy6), .out_vec(vec6),
        .out_err(oe6), .err_count(ec6));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode written from the arithmetic meaning of each mode.
    function automatic logic [63:0] ref_vec(input int size, input int k, input int mode);
        logic [63:0] mask;
        logic [63:0] one;
        one  = 64'd1;
        mask = (one << size) - 64'd1;
        if (k >= size) return 64'd0;
        case (mode)
            0:       return one << k;
            1:       return mask & ~(one << k);
            2:       return (one << (k + 1)) - 64'd1;
            3:       return mask & ~((one << k) - 64'd1);
            default: return 64'd0;
        endcase
    endfunction

    logic [6:0] q[$];
    logic [7:0] exp2[3];

    initial begin
        int delivered;
        int cyc;
        int err_drains;
        int sz;
        int k;
        int md;
        logic vin;

        rst = 1'b1;
        v8 = 1'b0; rdy8 = 1'b1; c8 = 3'd0; m8 = 2'd0;
        v5 = 1'b0; rdy5 = 1'b0; c5 = 3'd0; m5 = 2'd0;
        v6 = 1'b0; rdy6 = 1'b0; c6 = 3'd0; m6 = 2'd0;
        #2;
        chk("rst_out_valid", ov8, 1'b0);
        chk("rst_out_vec", vec8, 8'h00);
        chk("rst_out_err", oe8, 1'b0);
        chk("rst_in_ready", ir8, 1'b1);
        chk("rst_err_count", ec8, 16'h0000);
        step();
        rst = 1'b0;
        step();

        // One-hot codes 0..7 back-to-back, out_ready high
        for (int i = 0; i < 8; i++) begin
            v8 = 1'b1; c8 = 3'(i); m8 = 2'b00;
            chk("onehot_in_ready", ir8, 1'b1);
            step();
            chk("onehot_valid", ov8, 1'b1);
            chk("onehot_vec", vec8, ref_vec(8, i, 0));
        end
        v8 = 1'b0;
        step();
        chk("onehot_drained", ov8, 1'b0);

        // Code 3 in the other three modes
        exp2[0] = 8'hF7; exp2[1] = 8'h0F; exp2[2] = 8'hF8;
        for (int i = 0; i < 3; i++) begin
            v8 = 1'b1; c8 = 3'd3; m8 = 2'(i + 1);
            step();
            chk("mode_vec", vec8, exp2[i]);
            chk("mode_err", oe8, 1'b0);
        end
        v8 = 1'b0;
        step();

        // Backpressure: codes 1 then 2 with out_ready low
        rdy8 = 1'b0;
        v8 = 1'b1; c8 = 3'd1; m8 = 2'b00;
        step();
        c8 = 3'd2;
        chk("bp_in_ready_1", ir8, 1'b1);
        step();
        v8 = 1'b0;
        chk("bp_hold_vec", vec8, 8'h02);
        chk("bp_in_ready_0", ir8, 1'b0);
        step();
        chk("bp_still_vec", vec8, 8'h02);
        chk("bp_still_valid", ov8, 1'b1);
        rdy8 = 1'b1;
        step();
        chk("bp_second_vec", vec8, 8'h04);
        chk("bp_second_valid", ov8, 1'b1);
        chk("bp_ready_back", ir8, 1'b1);
        step();
        chk("bp_empty", ov8, 1'b0);

        // Reset asserted while in the skid state
        rdy8 = 1'b0;
        v8 = 1'b1; c8 = 3'd4;
        step();
        c8 = 3'd6;
        step();
        v8 = 1'b0;
        chk("rs_skid_full", ir8, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rs_async_valid", ov8, 1'b0);
        chk("rs_async_ready", ir8, 1'b1);
        chk("rs_async_vec", vec8, 8'h00);
        step();
        rst = 1'b0;
        rdy8 = 1'b1;
        v8 = 1'b1; c8 = 3'd5; m8 = 2'b00;
        step();
        v8 = 1'b0;
        chk("rs_new_vec", vec8, 8'h20);
        chk("rs_new_valid", ov8, 1'b1);
        step();
        chk("rs_no_stale", ov8, 1'b0);

        // SIZE=5 out-of-range code
        rdy5 = 1'b0;
        v5 = 1'b1; c5 = 3'd6; m5 = 2'b10;
        step();
        v5 = 1'b0;
        chk("oor_valid", ov5, 1'b1);
        chk("oor_vec", vec5, 5'b00000);
        chk("oor_err", oe5, 1'b1);
        chk("oor_cnt_pre", ec5, 16'h0000);
        rdy5 = 1'b1;
        step();
        chk("oor_drained", ov5, 1'b0);
`ifdef DECODER_N_PIPE_ERR_COUNT_EN
        chk("oor_cnt_post", ec5, 16'h0001);
`else
        chk("oor_cnt_post", ec5, 16'h0000);
`endif
        // Top in-range code on SIZE=5
        v5 = 1'b1; c5 = 3'd4; m5 = 2'b11;
        step();
        v5 = 1'b0;
        chk("top_vec", vec5, 5'b10000);
        chk("top_err", oe5, 1'b0);
        step();

`ifdef DECODER_N_PIPE_ERR_COUNT_EN
        v5 = 1'b1; c5 = 3'd6; m5 = 2'b10;
        repeat (100) step();
        v5 = 1'b0;
        step();
        chk("cnt_101", ec5, 16'd101);
        v5 = 1'b1;
        repeat (65439) step();
        v5 = 1'b0;
        step();
        step();
        chk("cnt_sat", ec5, 16'hFFFF);
`else
        v5 = 1'b1; c5 = 3'd7; m5 = 2'b00;
        repeat (50) step();
        v5 = 1'b0;
        step();
        step();
        chk("cnt_tied", ec5, 16'h0000);
`endif

        // Random valid/ready against a queue model, SIZE=6
        delivered = 0;
        cyc = 0;
        err_drains = 0;
        while (delivered < 10000 && cyc < 40000) begin
            rdy6 = ($urandom_range(0, 7) != 0);
            sz = q.size();
            chk("rnd_out_valid", ov6, (sz > 0));
            chk("rnd_in_ready", ir6, (sz < 2));
            if (sz > 0) begin
                chk("rnd_vec", vec6, q[0][5:0]);
                chk("rnd_err", oe6, q[0][6]);
            end
            vin = ($urandom_range(0, 3) != 0);
            v6 = vin;
            if (vin) begin
                k  = int'($urandom_range(0, 7));
                md = int'($urandom_range(0, 3));
                c6 = 3'(k);
                m6 = 2'(md);
            end else begin
                c6 = 3'bxxx;
                m6 = 2'bxx;
            end
            if (sz > 0 && rdy6) begin
                if (q[0][6]) err_drains++;
                void'(q.pop_front());
                delivered++;
            end
            if (vin && sz < 2) begin
                q.push_back({(k >= 6), ref_vec(6, k, md)[5:0]});
            end
            step();
            cyc++;
        end
        v6 = 1'b0;
        chk("rnd_count", 64'(delivered), 64'd10000);
        step();
        step();
`ifdef DECODER_N_PIPE_ERR_COUNT_EN
        chk("rnd_err_count", ec6, 16'(err_drains));
`else
        chk("rnd_err_count", ec6, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
